// File: rtl/alu_operand_stage_pkg.sv
// Shared widths, b-select encodings and the EX-stage payload for the ALU operand stage.
package alu_operand_stage_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned ALUC_W  = 4;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned BSEL_W  = 2;
    localparam int unsigned CNT_W   = 16;

    localparam logic [BSEL_W-1:0] B_RT   = 2'b00;
    localparam logic [BSEL_W-1:0] B_SEXT = 2'b01;
    localparam logic [BSEL_W-1:0] B_ZEXT = 2'b10;

    localparam logic [ALUC_W-1:0] ALUC_BUBBLE = 4'b0000;
    localparam logic [REG_AW-1:0] REG_ZERO    = 5'd0;

    typedef struct packed {
        logic [XLEN-1:0]   alu_a;
        logic [XLEN-1:0]   alu_b;
        logic [ALUC_W-1:0] aluc;
        logic              wr_en;
        logic [REG_AW-1:0] wr_addr;
        logic              mem_read;
        logic [XLEN-1:0]   store_data;
    } ex_payload_t;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Per-operand bypass select: r0 forces zero, then EX result, then MEM result, then register file.
module fwd_mux
    import alu_operand_stage_pkg::*;
(
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic [XLEN-1:0]   rd_data_i,
    input  logic              ex_fwd_en_i,
    input  logic [REG_AW-1:0] ex_wr_addr_i,
    input  logic [XLEN-1:0]   ex_result_i,
    input  logic              mem_wr_en_i,
    input  logic [REG_AW-1:0] mem_wr_addr_i,
    input  logic [XLEN-1:0]   mem_result_i,
    output logic [XLEN-1:0]   fwd_data_c_o
);

    always_comb begin
        fwd_data_c_o = rd_data_i;
        if (rd_addr_i == REG_ZERO) begin
            fwd_data_c_o = '0;
        end else if (ex_fwd_en_i && (ex_wr_addr_i == rd_addr_i)) begin
            fwd_data_c_o = ex_result_i;
        end else if (mem_wr_en_i && (mem_wr_addr_i == rd_addr_i)) begin
            fwd_data_c_o = mem_result_i;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: forwarding, operand select, load-use stall and the EX pipeline register.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs_addr,
    input  logic [REG_AW-1:0]   id_rt_addr,
    input  logic [XLEN-1:0]     id_rs_data,
    input  logic [XLEN-1:0]     id_rt_data,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic [IMM_W-1:0]    id_imm,
    input  logic [SHAMT_W-1:0]  id_shamt,
    input  logic [ALUC_W-1:0]   id_aluc,
    input  logic                id_a_shamt,
    input  logic [BSEL_W-1:0]   id_b_sel,
    input  logic                id_wr_en,
    input  logic [REG_AW-1:0]   id_wr_addr,
    input  logic                id_mem_read,
    input  logic [XLEN-1:0]     ex_result,
    input  logic                mem_wr_en,
    input  logic [REG_AW-1:0]   mem_wr_addr,
    input  logic [XLEN-1:0]     mem_result,
    input  logic                flush,
    output logic                id_stall,
    output logic                ex_valid,
    output logic [XLEN-1:0]     alu_a,
    output logic [XLEN-1:0]     alu_b,
    output logic [ALUC_W-1:0]   alu_aluc,
    output logic                ex_wr_en,
    output logic [REG_AW-1:0]   ex_wr_addr,
    output logic                ex_mem_read,
    output logic [XLEN-1:0]     ex_store_data,
    output logic [CNT_W-1:0]    stall_count
);

    logic              ex_valid_q, ex_valid_d;
    ex_payload_t       ex_q, ex_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              ex_fwd_en;
    logic              hazard;
    logic [XLEN-1:0]   rs_fwd, rt_fwd;

    // A load in EX has no result yet, so it must not be bypassed from ex_result.
    assign ex_fwd_en = ex_valid_q & ex_q.wr_en & ~ex_q.mem_read;

    fwd_mux u_fwd_rs (
        .rd_addr_i     (id_rs_addr),
        .rd_data_i     (id_rs_data),
        .ex_fwd_en_i   (ex_fwd_en),
        .ex_wr_addr_i  (ex_q.wr_addr),
        .ex_result_i   (ex_result),
        .mem_wr_en_i   (mem_wr_en),
        .mem_wr_addr_i (mem_wr_addr),
        .mem_result_i  (mem_result),
        .fwd_data_c_o  (rs_fwd)
    );

    fwd_mux u_fwd_rt (
        .rd_addr_i     (id_rt_addr),
        .rd_data_i     (id_rt_data),
        .ex_fwd_en_i   (ex_fwd_en),
        .ex_wr_addr_i  (ex_q.wr_addr),
        .ex_result_i   (ex_result),
        .mem_wr_en_i   (mem_wr_en),
        .mem_wr_addr_i (mem_wr_addr),
        .mem_result_i  (mem_result),
        .fwd_data_c_o  (rt_fwd)
    );

    assign hazard = id_valid & ex_valid_q & ex_q.mem_read & (ex_q.wr_addr != REG_ZERO) &
                    ((id_use_rs & (ex_q.wr_addr == id_rs_addr)) |
                     (id_use_rt & (ex_q.wr_addr == id_rt_addr)));

    assign id_stall = hazard & ~flush;

    // Next EX contents: capture only when not flushed, not stalled and valid; otherwise a zero bubble.
    always_comb begin
        ex_valid_d  = 1'b0;
        ex_d        = '0;
        ex_d.aluc   = ALUC_BUBBLE;
        stall_cnt_d = stall_cnt_q;

        if (!flush && !id_stall && id_valid) begin
            ex_valid_d      = 1'b1;
            ex_d.alu_a      = id_a_shamt ? XLEN'(id_shamt) : rs_fwd;
            case (id_b_sel)
                B_SEXT:  ex_d.alu_b = {{(XLEN-IMM_W){id_imm[IMM_W-1]}}, id_imm};
                B_ZEXT:  ex_d.alu_b = XLEN'(id_imm);
                default: ex_d.alu_b = rt_fwd;
            endcase
            ex_d.aluc       = id_aluc;
            ex_d.wr_en      = id_wr_en;
            ex_d.wr_addr    = id_wr_addr;
            ex_d.mem_read   = id_mem_read;
            ex_d.store_data = rt_fwd;
        end

        if (id_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign alu_a         = ex_q.alu_a;
    assign alu_b         = ex_q.alu_b;
    assign alu_aluc      = ex_q.aluc;
    assign ex_wr_en      = ex_q.wr_en;
    assign ex_wr_addr    = ex_q.wr_addr;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_store_data = ex_q.store_data;
    assign stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Table-driven bench for alu_operand_stage with a queue scoreboard and reset/stall sequences.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs_addr, id_rt_addr;
    logic [31:0] id_rs_data, id_rt_data;
    logic        id_use_rs, id_use_rt;
    logic [15:0] id_imm;
    logic [4:0]  id_shamt;
    logic [3:0]  id_aluc;
    logic        id_a_shamt;
    logic [1:0]  id_b_sel;
    logic        id_wr_en;
    logic [4:0]  id_wr_addr;
    logic        id_mem_read;
    logic [31:0] ex_result;
    logic        mem_wr_en;
    logic [4:0]  mem_wr_addr;
    logic [31:0] mem_result;
    logic        flush;
    logic        id_stall;
    logic        ex_valid;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_aluc;
    logic        ex_wr_en;
    logic [4:0]  ex_wr_addr;
    logic        ex_mem_read;
    logic [31:0] ex_store_data;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_aluc(id_aluc), .id_a_shamt(id_a_shamt),
        .id_b_sel(id_b_sel), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
        .id_mem_read(id_mem_read), .ex_result(ex_result), .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr), .mem_result(mem_result), .flush(flush),
        .id_stall(id_stall), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
        .alu_aluc(alu_aluc), .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr),
        .ex_mem_read(ex_mem_read), .ex_store_data(ex_store_data),
        .stall_count(stall_count)
    );

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs_addr;
        logic [31:0] rs_data;
        logic [4:0]  rt_addr;
        logic [31:0] rt_data;
        logic        use_rs, use_rt;
        logic [15:0] imm;
        logic [4:0]  shamt;
        logic        a_shamt;
        logic [1:0]  b_sel;
        logic [3:0]  aluc;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic        mem_read;
        logic [31:0] ex_result;
        logic        mem_wr_en;
        logic [4:0]  mem_wr_addr;
        logic [31:0] mem_result;
        logic        flush;
    } in_t;

    typedef struct packed {
        logic        ev;
        logic [31:0] a, b;
        logic [3:0]  aluc;
        logic        wen;
        logic [4:0]  waddr;
        logic        mrd;
        logic [31:0] sd;
        logic [15:0] sc;
    } out_t;

    typedef struct {
        in_t  in;
        logic stall;
        out_t exp;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];
    out_t sb_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic set_in(input int i, input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                          input logic [4:0] rt, input logic [31:0] rtd, input logic urs, input logic urt,
                          input logic [15:0] imm, input logic [4:0] sh, input logic ash,
                          input logic [1:0] bs, input logic [3:0] ac, input logic we,
                          input logic [4:0] wa, input logic mr);
        vecs[i].in = '0;
        vecs[i].in.valid = v;   vecs[i].in.rs_addr = rs; vecs[i].in.rs_data = rsd;
        vecs[i].in.rt_addr = rt; vecs[i].in.rt_data = rtd;
        vecs[i].in.use_rs = urs; vecs[i].in.use_rt = urt;
        vecs[i].in.imm = imm;   vecs[i].in.shamt = sh; vecs[i].in.a_shamt = ash;
        vecs[i].in.b_sel = bs;  vecs[i].in.aluc = ac;  vecs[i].in.wr_en = we;
        vecs[i].in.wr_addr = wa; vecs[i].in.mem_read = mr;
    endtask

    task automatic set_fwd(input int i, input logic [31:0] exr, input logic mwe,
                           input logic [4:0] mwa, input logic [31:0] mres, input logic fl);
        vecs[i].in.ex_result = exr; vecs[i].in.mem_wr_en = mwe;
        vecs[i].in.mem_wr_addr = mwa; vecs[i].in.mem_result = mres; vecs[i].in.flush = fl;
    endtask

    task automatic set_exp(input int i, input logic st, input logic ev, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] ac, input logic we,
                           input logic [4:0] wa, input logic mr, input logic [31:0] sd,
                           input logic [15:0] sc);
        vecs[i].stall = st;
        vecs[i].exp = '{ev: ev, a: a, b: b, aluc: ac, wen: we, waddr: wa, mrd: mr, sd: sd, sc: sc};
    endtask

    task automatic drive(input in_t x);
        id_valid = x.valid; id_rs_addr = x.rs_addr; id_rs_data = x.rs_data;
        id_rt_addr = x.rt_addr; id_rt_data = x.rt_data;
        id_use_rs = x.use_rs; id_use_rt = x.use_rt; id_imm = x.imm; id_shamt = x.shamt;
        id_a_shamt = x.a_shamt; id_b_sel = x.b_sel; id_aluc = x.aluc; id_wr_en = x.wr_en;
        id_wr_addr = x.wr_addr; id_mem_read = x.mem_read; ex_result = x.ex_result;
        mem_wr_en = x.mem_wr_en; mem_wr_addr = x.mem_wr_addr; mem_result = x.mem_result;
        flush = x.flush;
    endtask

    task automatic check_out(input string name, input out_t exp);
        out_t act;
        act = {ex_valid, alu_a, alu_b, alu_aluc, ex_wr_en, ex_wr_addr, ex_mem_read,
               ex_store_data, stall_count};
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got ev=%0b a=%h b=%h aluc=%h wen=%0b wa=%0d mr=%0b sd=%h sc=%0d ; want ev=%0b a=%h b=%h aluc=%h wen=%0b wa=%0d mr=%0b sd=%h sc=%0d",
                     name, act.ev, act.a, act.b, act.aluc, act.wen, act.waddr, act.mrd, act.sd, act.sc,
                     exp.ev, exp.a, exp.b, exp.aluc, exp.wen, exp.waddr, exp.mrd, exp.sd, exp.sc);
        end
    endtask

    task automatic check_stall(input string name, input logic exp);
        n_cmp++;
        if (id_stall !== exp) begin
            n_fail++;
            $display("FAIL %s: id_stall got %0b want %0b", name, id_stall, exp);
        end
    endtask

    task automatic pop_check(input string name);
        out_t e;
        if (sb_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: scoreboard empty got 0 entries want 1", name);
        end else begin
            e = sb_q.pop_front();
            check_out(name, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t  x;
        out_t zero_o;
        zero_o = '0;

        //            idx v rs  rs_data       rt  rt_data       urs urt imm       sh  ash bs     aluc  we wa  mr
        set_in (0,  1, 1,  32'h11,       2,  32'h22,       1,  1,  16'h0,    0,  0, 2'b00, 4'h3, 1, 5,  0);
        set_fwd(0,  32'h0, 0, 0, 32'h0, 0);
        set_exp(0,  0, 1, 32'h11, 32'h22, 4'h3, 1, 5, 0, 32'h22, 0);
        set_in (1,  1, 5,  32'h1,        0,  32'hDEAD,     1,  1,  16'h0,    0,  0, 2'b00, 4'h2, 1, 7,  0);
        set_fwd(1,  32'h10, 0, 0, 32'h0, 0);
        set_exp(1,  0, 1, 32'h10, 32'h0, 4'h2, 1, 7, 0, 32'h0, 0);
        set_in (2,  1, 0,  32'h55,       7,  32'h99,       1,  1,  16'h0,    0,  0, 2'b00, 4'h8, 1, 0,  0);
        set_fwd(2,  32'hA, 1, 7, 32'hB, 0);
        set_exp(2,  0, 1, 32'h0, 32'hA, 4'h8, 1, 0, 0, 32'hA, 0);
        set_in (3,  1, 9,  32'h33,       0,  32'h77,       1,  1,  16'h0,    0,  0, 2'b00, 4'h1, 0, 4,  0);
        set_fwd(3,  32'hC, 1, 0, 32'hD, 0);
        set_exp(3,  0, 1, 32'h33, 32'h0, 4'h1, 0, 4, 0, 32'h0, 0);
        set_in (4,  1, 4,  32'h1,        6,  32'h66,       1,  1,  16'h8001, 0,  0, 2'b01, 4'h5, 1, 3,  0);
        set_fwd(4,  32'hEEEE, 1, 4, 32'h44, 0);
        set_exp(4,  0, 1, 32'h44, 32'hFFFF_8001, 4'h5, 1, 3, 0, 32'h66, 0);
        set_in (5,  1, 3,  32'h0,        3,  32'h0,        1,  1,  16'h8001, 31, 1, 2'b10, 4'h6, 1, 2,  0);
        set_fwd(5,  32'h30, 0, 0, 32'h0, 0);
        set_exp(5,  0, 1, 32'h1F, 32'h0000_8001, 4'h6, 1, 2, 0, 32'h30, 0);
        set_in (6,  0, 1,  32'h5,        2,  32'h6,        1,  1,  16'h0,    0,  0, 2'b00, 4'h7, 1, 9,  0);
        set_fwd(6,  32'h0, 0, 0, 32'h0, 0);
        set_exp(6,  0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h0, 0);
        set_in (7,  1, 8,  32'h88,       8,  32'h88,       1,  1,  16'h0,    0,  0, 2'b11, 4'hF, 1, 3,  1);
        set_fwd(7,  32'h1234, 0, 0, 32'h0, 0);
        set_exp(7,  0, 1, 32'h88, 32'h88, 4'hF, 1, 3, 1, 32'h88, 0);
        set_in (8,  1, 0,  32'h0,        3,  32'h1,        0,  1,  16'h0,    0,  0, 2'b00, 4'h4, 1, 9,  0);
        set_fwd(8,  32'hBAD, 0, 0, 32'h0, 0);
        set_exp(8,  1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h0, 1);
        set_in (9,  1, 0,  32'h0,        3,  32'h1,        0,  1,  16'h0,    0,  0, 2'b00, 4'h4, 1, 9,  0);
        set_fwd(9,  32'hBAD, 1, 3, 32'h333, 0);
        set_exp(9,  0, 1, 32'h0, 32'h333, 4'h4, 1, 9, 0, 32'h333, 1);
        set_in (10, 1, 1,  32'h5,        2,  32'h6,        1,  1,  16'h0,    0,  0, 2'b00, 4'h3, 1, 5,  0);
        set_fwd(10, 32'h0, 0, 0, 32'h0, 1);
        set_exp(10, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h0, 1);
        set_in (11, 1, 1,  32'h1,        0,  32'h0,        1,  1,  16'h0004, 0,  0, 2'b01, 4'h0, 1, 12, 1);
        set_fwd(11, 32'h0, 0, 0, 32'h0, 0);
        set_exp(11, 0, 1, 32'h1, 32'h4, 4'h0, 1, 12, 1, 32'h0, 1);
        set_in (12, 1, 12, 32'h0,        0,  32'h0,        1,  0,  16'h0,    0,  0, 2'b00, 4'h2, 1, 1,  0);
        set_fwd(12, 32'h0, 0, 0, 32'h0, 1);
        set_exp(12, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h0, 1);

        rst_n = 1'b0;
        x = '0;
        drive(x);
        #12;
        check_out("reset_state", zero_o);
        check_stall("reset_stall", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].in);
            #1;
            check_stall($sformatf("vec%0d_stall", i), vecs[i].stall);
            sb_q.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            pop_check($sformatf("vec%0d_out", i));
        end

        // Load to r3 captured, dependent instruction raises stall, reset lands mid-cycle.
        @(negedge clk);
        x = '0; x.valid = 1; x.aluc = 4'h2; x.wr_en = 1; x.wr_addr = 5'd3; x.mem_read = 1;
        drive(x);
        sb_q.push_back('{ev: 1, a: 0, b: 0, aluc: 4'h2, wen: 1, waddr: 3, mrd: 1, sd: 0, sc: 1});
        @(posedge clk);
        #1;
        pop_check("load_capture");
        @(negedge clk);
        x = '0; x.valid = 1; x.rt_addr = 5'd3; x.use_rt = 1; x.aluc = 4'h1; x.wr_en = 1; x.wr_addr = 5'd4;
        drive(x);
        #1;
        check_stall("pre_reset_stall", 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_out("async_reset_outputs", zero_o);
        check_stall("async_reset_stall", 1'b0);
        x = '0;
        drive(x);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back(zero_o);
        @(posedge clk);
        #1;
        pop_check("post_reset_idle");
        @(posedge clk);
        #1;
        check_out("post_reset_idle2", zero_o);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-002 Decode inputs SHALL be:
- id_valid in 1; id_rs_addr, id_rt_addr in 5; id_rs_data, id_rt_data in 32 (register-file read data, write-through).
- id_use_rs, id_use_rt in 1; id_imm in 16; id_shamt in 5; id_aluc in 4.
- id_a_shamt in 1 (1: a = shamt); id_b_sel in 2 (00 rt, 01 sign-ext imm, 10 zero-ext imm, 11 reserved = rt).
- id_wr_en in 1; id_wr_addr in 5; id_mem_read in 1.
REQ-003 Forwarding inputs SHALL be: ex_result in 32 (current ALU r); mem_wr_en in 1; mem_wr_addr in 5; mem_result in 32.
REQ-004 Control SHALL be: flush in 1 (kill ID-stage instruction); id_stall out 1 (load-use hold request to fetch/decode).
REQ-005 Outputs SHALL be: ex_valid, alu_a (32), alu_b (32), alu_aluc (4), ex_wr_en, ex_wr_addr (5), ex_mem_read, ex_store_data (32), stall_count (16), all registered.

Function
REQ-006 Source selection SHALL be per operand (rs, rt), in priority order, each with addr != 0:
- EX match: ex_valid & ex_wr_en & ~ex_mem_read & ex_wr_addr == addr -> ex_result.
- MEM match: mem_wr_en & mem_wr_addr == addr -> mem_result.
- else: id_*_data.
REQ-007 Register 0 SHALL always read as 32'h0, regardless of id data or forwarding.
REQ-008 Operand a SHALL be {27'b0, id_shamt} when id_a_shamt=1, else the forwarded rs.
REQ-009 Operand b SHALL be per id_b_sel: forwarded rt; {{16{imm[15]}}, imm}; or {16'b0, imm}.
REQ-010 ex_store_data SHALL capture the forwarded rt irrespective of id_b_sel.
REQ-011 Load-use hazard SHALL be: id_valid & ex_valid & ex_mem_read & ex_wr_addr != 0 & ((id_use_rs & ex_wr_addr == id_rs_addr) | (id_use_rt & ex_wr_addr == id_rt_addr)).
REQ-012 id_stall SHALL be combinational: hazard & ~flush.
REQ-013 Per rising edge the stage SHALL take exactly one action, in priority order:
- flush=1 -> bubble.
- id_stall=1 -> bubble.
- id_valid=0 -> bubble.
- else -> capture operands and control.
REQ-014 A capture SHALL set ex_valid=1 and load alu_a, alu_b, alu_aluc=id_aluc, ex_wr_en, ex_wr_addr, ex_mem_read, ex_store_data.
REQ-015 A bubble SHALL set ex_valid, ex_wr_en and ex_mem_read to 0, and alu_a, alu_b, alu_aluc, ex_wr_addr, ex_store_data to 0 (aluc 0000 = unsigned add, side-effect free).
REQ-016 Latency SHALL be one cycle from ID inputs to outputs, with no combinational path from inputs to registered outputs.
REQ-017 stall_count SHALL increment on each edge where id_stall=1, saturating at 16'hFFFF.
REQ-018 A stall SHALL last exactly one cycle per load: the following cycle the load has left EX and MEM forwarding supplies the value.

Reset
REQ-019 rst_n=0 SHALL immediately force every registered output to 0, including stall_count, independent of clk.
REQ-020 Release of rst_n SHALL produce bubbles until the first edge with id_valid=1.
REQ-021 Reset asserted mid-stall SHALL discard the pending load; id_stall SHALL then be 0, because ex_valid=0.

Structure
REQ-022 A shared package SHALL hold: the b-select encodings (B_RT, B_SEXT, B_ZEXT), the ALU control width and bubble code (4'b0000), and REG_ZERO=5'd0.
REQ-023 The forwarding mux SHALL be one sub-module, fwd_mux, instantiated twice (rs, rt); the hazard logic and pipeline register SHALL stay in the top module.

Verification
REQ-024 Scenario, EX forward: previous instruction writes r5 and ex_result=32'h0000_0010; id reads rs=r5 with rs data 32'h1 -> alu_a=32'h10.
REQ-025 Scenario, priority: EX and MEM both target r7 (ex_result=32'hA, mem_result=32'hB) -> forwarded rt=32'hA; with r0 in place of r7 -> 32'h0.
REQ-026 Scenario, load-use: a load to r3 is in EX and id uses rt=r3 -> id_stall=1 for one cycle, then a bubble (ex_valid=0, alu_aluc=0), then a capture via mem_result; stall_count goes 0 -> 1.
REQ-027 Scenario, immediate: id_imm=16'h8001 -> b_sel=01 gives alu_b=32'hFFFF_8001; b_sel=10 gives 32'h0000_8001; id_a_shamt=1 with shamt=5'd31 -> alu_a=32'h1F.
REQ-028 Scenario, flush during hazard: flush=1 -> id_stall=0, bubble next edge, stall_count unchanged.
REQ-029 Scenario, async reset: rst_n falls between edges while ex_valid=1 -> all outputs 0 before the next edge; after release with id_valid=0 -> ex_valid stays 0.
